axi4_error_slave: RTL and testbench

- Full-AXI4 default/error slave. It terminates every transaction that the interconnect decodes to an unmapped region.
- Supports INCR/FIXED/WRAP bursts of 1..256 beats on both channels, with a per-direction error response selectable by parameter.
- Provides saturating transaction counters and a sticky protocol-violation flag for debug CSRs.
- Sits on the interconnect's default-slave port, in place of the single-beat AXI-lite error slave.

---
 rtl/axi4_error_slave_if.sv | 58 +++++
 rtl/axi4_error_slave.sv | 185 ++++++++++++++++++
 tb/tb_axi4_error_slave.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_error_slave_if.sv
// AXI4 bus interface carrying the fields the default/error slave sees.
// Address and write-data fields are present only for compatibility with the interconnect.
interface axi4_if #(
  parameter int A = 32,
  parameter int N = 8,
  parameter int I = 1
);
  logic [I-1:0]   awid;
  logic [A-1:0]   awaddr;
  logic [7:0]     awlen;
  logic           awvalid;
  logic           awready;
  logic [8*N-1:0] wdata;
  logic           wlast;
  logic           wvalid;
  logic           wready;
  logic [I-1:0]   bid;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  logic [I-1:0]   arid;
  logic [A-1:0]   araddr;
  logic [7:0]     arlen;
  logic           arvalid;
  logic           arready;
  logic [I-1:0]   rid;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    output awready,
    input  wdata, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awvalid,
    input  awready,
    output wdata, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_error_slave.sv
// Full-AXI4 default slave: absorbs every burst routed to unmapped space and answers with an
// error response, keeping saturating completion counters and a sticky wlast-mismatch flag.
module axi4_error_slave #(
  parameter int          A          = 32,
  parameter int          N          = 8,
  parameter int          I          = 1,
  parameter logic [1:0]  WR_RESP    = 2'b11,
  parameter logic [1:0]  RD_RESP    = 2'b11,
  parameter logic [31:0] RD_PATTERN = 32'heeeec0de,
  parameter int          CW         = 16
) (
  input  logic          aclk,
  input  logic          aresetn,
  axi4_if.slave         axi4_s,
  input  logic          cnt_clr,
  output logic [CW-1:0] wr_err_cnt,
  output logic [CW-1:0] rd_err_cnt,
  output logic          wlast_err
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  localparam logic [CW-1:0] CNT_MAX = '1;

  wstate_e        wstate_q, wstate_d;
  logic [7:0]     wcnt_q, wcnt_d;
  logic [I-1:0]   bid_q, bid_d;
  logic           awready_q, awready_d;
  logic           wready_q, wready_d;
  logic           bvalid_q, bvalid_d;

  rstate_e        rstate_q, rstate_d;
  logic [7:0]     rcnt_q, rcnt_d;
  logic [I-1:0]   rid_q, rid_d;
  logic           arready_q, arready_d;
  logic           rvalid_q, rvalid_d;
  logic           rlast_q, rlast_d;

  logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
  logic           wlast_err_q, wlast_err_d;
  logic           wlast_mismatch;

  logic           aw_hs, w_hs, b_hs, ar_hs, r_hs, rd_done;
  logic [8*N-1:0] rdata_pat;

  assign aw_hs   = axi4_s.awvalid & awready_q;
  assign w_hs    = axi4_s.wvalid  & wready_q;
  assign b_hs    = bvalid_q       & axi4_s.bready;
  assign ar_hs   = axi4_s.arvalid & arready_q;
  assign r_hs    = rvalid_q       & axi4_s.rready;
  assign rd_done = r_hs & rlast_q;

  // Burst length comes only from awlen; wlast is merely checked against it.
  always_comb begin
    wstate_d       = wstate_q;
    wcnt_d         = wcnt_q;
    bid_d          = bid_q;
    wlast_mismatch = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          bid_d    = axi4_s.awid;
          wcnt_d   = axi4_s.awlen;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          wlast_mismatch = axi4_s.wlast != (wcnt_q == 8'd0);
          if (wcnt_q == 8'd0) wstate_d = W_RESP;
          else                wcnt_d   = wcnt_q - 8'd1;
        end
      end
      W_RESP: begin
        if (b_hs) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE);
    wready_d  = (wstate_d == W_DATA);
    bvalid_d  = (wstate_d == W_RESP);
  end

  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rid_d    = rid_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rid_d    = axi4_s.arid;
          rcnt_d   = axi4_s.arlen;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (rcnt_q == 8'd0) rstate_d = R_IDLE;
          else                rcnt_d   = rcnt_q - 8'd1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_DATA);
    rlast_d   = (rstate_d == R_DATA) && (rcnt_d == 8'd0);
  end

  // A clear that lands on an event keeps that event rather than dropping it.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wlast_err_d = wlast_err_q | wlast_mismatch;
    if (cnt_clr) begin
      wr_cnt_d    = b_hs    ? CW'(1) : '0;
      rd_cnt_d    = rd_done ? CW'(1) : '0;
      wlast_err_d = wlast_mismatch;
    end else begin
      if (b_hs && (wr_cnt_q != CNT_MAX))    wr_cnt_d = wr_cnt_q + CW'(1);
      if (rd_done && (rd_cnt_q != CNT_MAX)) rd_cnt_d = rd_cnt_q + CW'(1);
    end
  end

  always_comb begin
    rdata_pat = '0;
    for (int i = 0; i < N; i++) begin
      rdata_pat[8*i +: 8] = RD_PATTERN[8*(i%4) +: 8];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate_q    <= W_IDLE;
      wcnt_q      <= '0;
      bid_q       <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      rstate_q    <= R_IDLE;
      rcnt_q      <= '0;
      rid_q       <= '0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      wcnt_q      <= wcnt_d;
      bid_q       <= bid_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      rstate_q    <= rstate_d;
      rcnt_q      <= rcnt_d;
      rid_q       <= rid_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  assign axi4_s.awready = awready_q;
  assign axi4_s.wready  = wready_q;
  assign axi4_s.bvalid  = bvalid_q;
  assign axi4_s.bid     = bid_q;
  assign axi4_s.bresp   = WR_RESP;
  assign axi4_s.arready = arready_q;
  assign axi4_s.rvalid  = rvalid_q;
  assign axi4_s.rid     = rid_q;
  assign axi4_s.rdata   = rdata_pat;
  assign axi4_s.rresp   = RD_RESP;
  assign axi4_s.rlast   = rlast_q;

  assign wr_err_cnt = wr_cnt_q;
  assign rd_err_cnt = rd_cnt_q;
  assign wlast_err  = wlast_err_q;

endmodule

// File: tb/tb_axi4_error_slave.sv
// Directed bench for axi4_error_slave: one task per scenario, expected values written by hand.
// A second instance with CW=2 exercises counter saturation.
module tb_axi4_error_slave;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] wr_err_cnt, rd_err_cnt;
  logic        wlast_err;
  logic [1:0]  s_wr_cnt, s_rd_cnt;
  logic        s_wlast_err;
  int          checks = 0;
  int          errors = 0;

  localparam logic [63:0] EXP_RDATA = 64'heeeec0de_eeeec0de;

  axi4_if #(.A(32), .N(8), .I(1)) bus ();
  axi4_if #(.A(32), .N(8), .I(1)) sbus ();

  always #5 aclk = ~aclk;

  axi4_error_slave #(.A(32), .N(8), .I(1), .CW(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .axi4_s(bus.slave), .cnt_clr(cnt_clr),
    .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt), .wlast_err(wlast_err)
  );

  axi4_error_slave #(.A(32), .N(8), .I(1), .CW(2)) dut_sat (
    .aclk(aclk), .aresetn(aresetn), .axi4_s(sbus.slave), .cnt_clr(1'b0),
    .wr_err_cnt(s_wr_cnt), .rd_err_cnt(s_rd_cnt), .wlast_err(s_wlast_err)
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    sbus.awid = '0; sbus.awaddr = '0; sbus.awlen = '0; sbus.awvalid = 1'b0;
    sbus.wdata = '0; sbus.wlast = 1'b0; sbus.wvalid = 1'b0; sbus.bready = 1'b0;
    sbus.arid = '0; sbus.araddr = '0; sbus.arlen = '0; sbus.arvalid = 1'b0; sbus.rready = 1'b0;
  endtask

  task automatic test_reset;
    logic [4:0] hs;
    aresetn = 1'b0;
    idle_inputs();
    repeat (3) tick();
    hs = {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid};
    checks++;
    if (hs !== 5'b00000) begin
      errors++; $display("[TB] FAIL reset_handshakes got %b want 00000", hs);
    end
    checks++;
    if ({wr_err_cnt, rd_err_cnt, wlast_err} !== 33'd0) begin
      errors++; $display("[TB] FAIL reset_counters got %0h/%0h/%0b want 0/0/0", wr_err_cnt, rd_err_cnt, wlast_err);
    end
    aresetn = 1'b1;
    tick();
    hs = {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid};
    checks++;
    if (hs !== 5'b10010) begin
      errors++; $display("[TB] FAIL post_reset_ready got %b want 10010", hs);
    end
  endtask

  task automatic test_single_write;
    bus.awvalid = 1'b1; bus.awid = 1'b1; bus.awlen = 8'd0; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.awid = 1'b0;
    checks++;
    if ({bus.awready, bus.wready} !== 2'b01) begin
      errors++; $display("[TB] FAIL aw_to_wready got %b want 01", {bus.awready, bus.wready});
    end
    bus.wvalid = 1'b1; bus.wlast = 1'b1;
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    checks++;
    if ({bus.bvalid, bus.bid, bus.bresp} !== 4'b1111) begin
      errors++; $display("[TB] FAIL single_b got %b want 1111", {bus.bvalid, bus.bid, bus.bresp});
    end
    tick();
    checks++;
    if ({bus.bvalid, bus.awready} !== 2'b01) begin
      errors++; $display("[TB] FAIL b_to_awready got %b want 01", {bus.bvalid, bus.awready});
    end
    checks++;
    if (wr_err_cnt !== 16'd1 || wlast_err !== 1'b0) begin
      errors++; $display("[TB] FAIL single_cnt got %0d/%0b want 1/0", wr_err_cnt, wlast_err);
    end
    bus.bready = 1'b0;
  endtask

  task automatic test_read_burst;
    int beats = 0, bad = 0, last_cyc = -1;
    bus.arvalid = 1'b1; bus.arid = 1'b1; bus.arlen = 8'd255; bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0; bus.arid = 1'b0; bus.arlen = 8'd0;
    for (int c = 0; c < 300; c++) begin
      if (bus.rvalid === 1'b1) begin
        beats++;
        if (bus.rdata !== EXP_RDATA || bus.rresp !== 2'b11 || bus.rid !== 1'b1 ||
            bus.rlast !== (beats == 256)) bad++;
        if (bus.rlast === 1'b1) begin
          last_cyc = c;
          tick();
          break;
        end
      end
      tick();
    end
    bus.rready = 1'b0;
    checks++;
    if (beats !== 256 || last_cyc !== 255) begin
      errors++; $display("[TB] FAIL burst256_beats got %0d beats last at %0d want 256 at 255", beats, last_cyc);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("[TB] FAIL burst256_fields got %0d bad beats want 0", bad);
    end
    checks++;
    if ({bus.arready, bus.rvalid} !== 2'b10 || rd_err_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL burst256_end got %b cnt %0d want 10 cnt 1", {bus.arready, bus.rvalid}, rd_err_cnt);
    end
  endtask

  task automatic test_backpressure;
    int beats = 0, bad = 0, held = 0;
    logic stall = 1'b0;
    logic [63:0] sv_data = '0;
    logic sv_last = 1'b0, sv_id = 1'b0;
    bus.arvalid = 1'b1; bus.arid = 1'b0; bus.arlen = 8'd3; bus.rready = 1'b0;
    tick();
    bus.arvalid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (beats == 4) break;
      bus.rready = (c % 2 == 0);
      if (bus.rvalid === 1'b1) begin
        if (stall && (bus.rdata !== sv_data || bus.rlast !== sv_last || bus.rid !== sv_id)) bad++;
        if (bus.rid !== 1'b0 || bus.rlast !== (beats == 3)) bad++;
        if (bus.rready) beats++;
        stall = !bus.rready;
        sv_data = bus.rdata; sv_last = bus.rlast; sv_id = bus.rid;
      end
      tick();
    end
    bus.rready = 1'b0;
    checks++;
    if (beats !== 4 || bad !== 0) begin
      errors++; $display("[TB] FAIL stall_read got %0d beats %0d bad want 4 beats 0 bad", beats, bad);
    end
    checks++;
    if ({bus.arready, bus.rvalid} !== 2'b10 || rd_err_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL stall_read_end got %b cnt %0d want 10 cnt 2", {bus.arready, bus.rvalid}, rd_err_cnt);
    end
    bus.awvalid = 1'b1; bus.awid = 1'b1; bus.awlen = 8'd0; bus.bready = 1'b0;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wlast = 1'b1;
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.bvalid === 1'b1 && bus.bid === 1'b1) held++;
      tick();
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    checks++;
    if (held !== 5 || bus.bvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL b_stall got held %0d bvalid %b want 5 and 0", held, bus.bvalid);
    end
    checks++;
    if (wr_err_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL b_stall_cnt got %0d want 2", wr_err_cnt);
    end
  endtask

  task automatic test_protocol_error;
    bus.awvalid = 1'b1; bus.awid = 1'b0; bus.awlen = 8'd2; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.wvalid = 1'b1; bus.wlast = (b == 1);
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    checks++;
    if ({bus.bvalid, bus.bid, bus.wready, wlast_err} !== 4'b1001) begin
      errors++; $display("[TB] FAIL wlast_err_b got %b want 1001", {bus.bvalid, bus.bid, bus.wready, wlast_err});
    end
    tick();
    checks++;
    if ({bus.bvalid, bus.awready} !== 2'b01 || wr_err_cnt !== 16'd3) begin
      errors++; $display("[TB] FAIL wlast_err_end got %b cnt %0d want 01 cnt 3", {bus.bvalid, bus.awready}, wr_err_cnt);
    end
    bus.bready = 1'b0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (wlast_err !== 1'b0 || wr_err_cnt !== 16'd0 || rd_err_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL cnt_clr got %0b/%0d/%0d want 0/0/0", wlast_err, wr_err_cnt, rd_err_cnt);
    end
  endtask

  task automatic test_clear_collision;
    bus.awvalid = 1'b1; bus.awid = 1'b1; bus.awlen = 8'd0; bus.bready = 1'b0;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wlast = 1'b0; cnt_clr = 1'b1;
    tick();
    bus.wvalid = 1'b0; cnt_clr = 1'b0;
    checks++;
    if (wlast_err !== 1'b1 || bus.bvalid !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_vs_mismatch got %0b bvalid %b want 1 and 1", wlast_err, bus.bvalid);
    end
    bus.bready = 1'b1; cnt_clr = 1'b1;
    tick();
    bus.bready = 1'b0; cnt_clr = 1'b0;
    checks++;
    if (wr_err_cnt !== 16'd1 || wlast_err !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_vs_incr got %0d/%0b want 1/0", wr_err_cnt, wlast_err);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    int blocked = 0, beats = 1, bad = 0;
    bus.bready = 1'b0;
    bus.arvalid = 1'b1; bus.arid = 1'b1; bus.arlen = 8'd7; bus.rready = 1'b0;
    bus.wvalid = 1'b1; bus.wlast = 1'b1;
    tick();
    bus.arvalid = 1'b0; bus.arid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.wready !== 1'b0 || bus.rvalid !== 1'b1) blocked++;
      tick();
    end
    checks++;
    if (blocked !== 0) begin
      errors++; $display("[TB] FAIL w_before_aw got %0d bad cycles want 0", blocked);
    end
    bus.awvalid = 1'b1; bus.awid = 1'b0; bus.awlen = 8'd0;
    tick();
    bus.awvalid = 1'b0;
    checks++;
    if (bus.wready !== 1'b1) begin
      errors++; $display("[TB] FAIL w_after_aw got %b want 1", bus.wready);
    end
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    checks++;
    if ({bus.bvalid, bus.bid, bus.rvalid, bus.rid} !== 4'b1011) begin
      errors++; $display("[TB] FAIL concurrent_ids got %b want 1011", {bus.bvalid, bus.bid, bus.rvalid, bus.rid});
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rvalid === 1'b1) begin
        beats++;
        if (bus.rid !== 1'b1) bad++;
        if (bus.rlast === 1'b1) begin
          tick();
          break;
        end
      end
      tick();
    end
    bus.rready = 1'b0;
    checks++;
    if (beats !== 8 || bad !== 0) begin
      errors++; $display("[TB] FAIL concurrent_read got %0d beats %0d bad want 8 and 0", beats, bad);
    end
    checks++;
    if (wr_err_cnt !== 16'd1 || rd_err_cnt !== 16'd1 || bus.bvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL concurrent_cnt got %0d/%0d bvalid %b want 1/1/0", wr_err_cnt, rd_err_cnt, bus.bvalid);
    end
  endtask

  task automatic test_reset_mid_burst;
    int beats = 0;
    bus.arvalid = 1'b1; bus.arid = 1'b0; bus.arlen = 8'd15; bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    repeat (2) tick();
    aresetn = 1'b0;
    tick();
    checks++;
    if ({bus.rvalid, bus.arready} !== 2'b00) begin
      errors++; $display("[TB] FAIL mid_reset_r got %b want 00", {bus.rvalid, bus.arready});
    end
    tick();
    checks++;
    if ({bus.arready, bus.awready} !== 2'b00 || wr_err_cnt !== 16'd0 || rd_err_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL mid_reset_hold got %b cnt %0d/%0d want 00 0/0", {bus.arready, bus.awready}, wr_err_cnt, rd_err_cnt);
    end
    aresetn = 1'b1;
    tick();
    checks++;
    if ({bus.arready, bus.rvalid} !== 2'b10) begin
      errors++; $display("[TB] FAIL mid_reset_release got %b want 10", {bus.arready, bus.rvalid});
    end
    bus.arvalid = 1'b1; bus.arid = 1'b1; bus.arlen = 8'd1;
    tick();
    bus.arvalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rvalid === 1'b1) begin
        beats++;
        if (bus.rlast === 1'b1) begin
          tick();
          break;
        end
      end
      tick();
    end
    bus.rready = 1'b0;
    checks++;
    if (beats !== 2 || rd_err_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL post_reset_read got %0d beats cnt %0d want 2 cnt 1", beats, rd_err_cnt);
    end
  endtask

  task automatic test_saturation;
    int hs = 0;
    logic [1:0] cnt_at3 = '0;
    sbus.awvalid = 1'b1; sbus.awlen = 8'd0; sbus.wvalid = 1'b1; sbus.wlast = 1'b1; sbus.bready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (sbus.bvalid === 1'b1) begin
        hs++;
        if (hs == 3) cnt_at3 = s_wr_cnt;
        if (hs == 5) begin
          sbus.awvalid = 1'b0; sbus.wvalid = 1'b0;
          tick();
          break;
        end
      end
      tick();
    end
    sbus.awvalid = 1'b0; sbus.wvalid = 1'b0; sbus.bready = 1'b0;
    checks++;
    if (hs !== 5 || cnt_at3 !== 2'd2) begin
      errors++; $display("[TB] FAIL sat_progress got %0d writes cnt %0d at third want 5 and 2", hs, cnt_at3);
    end
    checks++;
    if (s_wr_cnt !== 2'd3 || s_wlast_err !== 1'b0) begin
      errors++; $display("[TB] FAIL sat_value got %0d/%0b want 3/0", s_wr_cnt, s_wlast_err);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_backpressure();
    test_protocol_error();
    test_clear_collision();
    test_back_to_back();
    test_reset_mid_burst();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
